// File: rtl/vec_decrypt_unit.sv
// ============================================================================
// vec_decrypt_unit
// ----------------------------------------------------------------------------
// Multi-cycle inverse of the 8-lane vector encrypt datapath. Recovers a 64-bit
// plaintext vector (8 lanes x 8 bits) from a ciphertext vector by undoing the
// encrypt steps in reverse order, one step per cycle:
//   XOR with XOR_KEY  ->  subtract lane key mod 256  ->  rotate-right by SHIFT
// Each step can be individually disabled through in_mask; a disabled step
// still occupies its cycle, so latency does not depend on the mask.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   in_valid    ciphertext vector valid
//   in_ready    block can accept a vector (high only when idle)
//   in_vec      ciphertext, lane i = [8i+7:8i]
//   in_mask     step enables: [2] XOR, [1] SUB, [0] ROT
//   out_valid   plaintext result valid
//   out_ready   downstream accepts the result
//   out_vec     plaintext result (holds last value until the next result)
//   busy        high whenever the block is not idle
//   done_count  completed output handshakes, wraps FFFF -> 0000
// ============================================================================
module vec_decrypt_unit #(
    parameter int unsigned  SHIFT   = 3,
    parameter logic [7:0]   XOR_KEY = 8'hAC,
    parameter logic [63:0]  ADD_KEY = 64'hEE439ADB03C9F70D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_vec,
    input  logic [2:0]  in_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_vec,
    output logic        busy,
    output logic [15:0] done_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_XOR  = 3'd1;
    localparam logic [2:0] ST_SUB  = 3'd2;
    localparam logic [2:0] ST_ROT  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Rotate amount reduced to a lane width so out-of-range values cannot
    // produce a zero result instead of a rotation.
    localparam int unsigned ROT_AMT = SHIFT % 8;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  state_q,      state_d;
    logic [63:0] w_q,          w_d;
    logic [2:0]  mask_q,       mask_d;
    logic [63:0] out_vec_q,    out_vec_d;
    logic        out_valid_q,  out_valid_d;
    logic [15:0] done_count_q, done_count_d;

    // ------------------------------------------------------------------------
    // Per-lane datapath results (computed from the working register)
    // ------------------------------------------------------------------------
    logic [63:0] xor_res;
    logic [63:0] sub_res;
    logic [63:0] rot_res;

    // Rotate right within one 8-bit lane. Doubling the lane and shifting the
    // 16-bit value keeps SHIFT = 0 an identity without a special case.
    function automatic logic [7:0] lane_rotr(input logic [7:0] b);
        logic [15:0] dbl;
        dbl = {b, b} >> ROT_AMT;
        return dbl[7:0];
    endfunction

    always_comb begin
        xor_res = '0;
        sub_res = '0;
        rot_res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            xor_res[8*i +: 8] = w_q[8*i +: 8] ^ XOR_KEY;
            // 8-bit subtraction per lane: the borrow is dropped, never
            // propagated into the neighbouring lane.
            sub_res[8*i +: 8] = w_q[8*i +: 8] - ADD_KEY[8*i +: 8];
            rot_res[8*i +: 8] = lane_rotr(w_q[8*i +: 8]);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        mask_d       = mask_q;
        out_vec_d    = out_vec_q;
        out_valid_d  = out_valid_q;
        done_count_d = done_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_d     = in_vec;
                    mask_d  = in_mask;
                    state_d = ST_XOR;
                end
            end

            ST_XOR: begin
                if (mask_q[2]) begin
                    w_d = xor_res;
                end
                state_d = ST_SUB;
            end

            ST_SUB: begin
                if (mask_q[1]) begin
                    w_d = sub_res;
                end
                state_d = ST_ROT;
            end

            ST_ROT: begin
                // The final value goes straight into the output register so
                // out_vec is already correct in the first DONE cycle and stays
                // frozen afterwards, independent of later use of w.
                if (mask_q[0]) begin
                    w_d = rot_res;
                end
                out_vec_d   = mask_q[0] ? rot_res : w_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            w_q          <= '0;
            mask_q       <= '0;
            out_vec_q    <= '0;
            out_valid_q  <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            mask_q       <= mask_d;
            out_vec_q    <= out_vec_d;
            out_valid_q  <= out_valid_d;
            done_count_q <= done_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_vec    = out_vec_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_vec_decrypt_unit.sv
// ============================================================================
// tb_vec_decrypt_unit
// ----------------------------------------------------------------------------
// Directed bench for vec_decrypt_unit with hand-computed expected vectors.
// Inputs are driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_vec_decrypt_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_vec;
    logic [2:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vec;
    logic        busy;
    logic [15:0] done_count;

    int n_checks;
    int n_pass;

    logic [63:0] held_vec;

    vec_decrypt_unit #(
        .SHIFT   (3),
        .XOR_KEY (8'hAC),
        .ADD_KEY (64'hEE439ADB03C9F70D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a vector in IDLE, accept it, and check the 4-edge latency
    // (accept edge counted as edge 1), the result, and the handshake.
    task automatic run_vec(input string tag, input logic [63:0] v, input logic [2:0] m,
                           input logic [63:0] exp, input logic [15:0] cnt_before);
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = v;
        in_mask  = m;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);                         // edge 1: accept
        in_valid = 1'b0;
        in_vec   = '1;                          // must not affect in-flight vector
        in_mask  = 3'b111;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_valid_e1"}, 64'(out_valid), 64'd0);
        @(negedge clk);                         // edge 2
        @(negedge clk);                         // edge 3
        chk({tag, "_valid_e3"}, 64'(out_valid), 64'd0);
        @(negedge clk);                         // edge 4: DONE
        chk({tag, "_valid_e4"}, 64'(out_valid), 64'd1);
        chk({tag, "_out_vec"}, out_vec, exp);
        @(negedge clk);                         // handshake edge
        chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_count"}, 64'(done_count), 64'(cnt_before + 16'd1));
        chk({tag, "_hold"}, out_vec, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        in_mask   = '0;
        out_ready = 1'b0;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_vec", out_vec, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(done_count), 64'd0);
        rst = 1'b1;

        // ---------------- reset mid-SUB discards in-flight vector
        @(negedge clk);
        in_valid  = 1'b1;
        in_vec    = 64'h5AE70E4FA77D53B9;
        in_mask   = 3'b111;
        out_ready = 1'b1;
        @(negedge clk);                         // accepted, in XOR
        in_valid = 1'b0;
        @(posedge clk);                         // -> SUB
        #2;
        rst = 1'b0;                             // asynchronous, mid-cycle
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_vec", out_vec, 64'd0);
        chk("midrst_count", 64'(done_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_output", 64'({out_valid, done_count}), 64'd0);
        end

        // ---------------- full decrypt
        run_vec("full", 64'h5AE70E4FA77D53B9, 3'b111, 64'h0101010101010101, 16'd0);
        // ---------------- XOR only
        run_vec("xor", 64'h0, 3'b100, 64'hACACACACACACACAC, 16'd1);
        // ---------------- SUB only with per-lane wrap
        run_vec("sub", 64'h0, 3'b010, 64'h12BD6625FD3709F3, 16'd2);
        // ---------------- ROT only
        run_vec("rot", 64'h0101010101010101, 3'b001, 64'h2020202020202020, 16'd3);
        // ---------------- no stages: identity, same latency
        run_vec("none", 64'h0123456789ABCDEF, 3'b000, 64'h0123456789ABCDEF, 16'd4);

        // ---------------- backpressure
        @(negedge clk);
        in_valid  = 1'b1;
        in_vec    = 64'h0;
        in_mask   = 3'b100;
        out_ready = 1'b0;
        @(negedge clk);                         // accepted
        in_valid = 1'b0;
        repeat (3) @(negedge clk);              // DONE
        chk("bp_valid", 64'(out_valid), 64'd1);
        held_vec = out_vec;
        chk("bp_vec", held_vec, 64'hACACACACACACACAC);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_vec   = 64'hDEADBEEFCAFEF00D;
            in_mask  = 3'(i);
            @(negedge clk);
            chk("bp_stable", out_vec, 64'hACACACACACACACAC);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_still_valid", 64'(out_valid), 64'd1);
        end
        chk("bp_count_held", 64'(done_count), 64'd5);
        // release; next vector waiting on the input
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 64'h1122334455667788;
        in_mask   = 3'b000;
        @(negedge clk);                         // handshake
        chk("bp_rel_count", 64'(done_count), 64'd6);
        chk("bp_rel_valid", 64'(out_valid), 64'd0);
        chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);                         // next vector accepted
        in_valid = 1'b0;
        chk("bp_next_busy", 64'(busy), 64'd1);
        chk("bp_next_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_vec", out_vec, 64'h1122334455667788);
        @(negedge clk);
        chk("bp_single_hs", 64'(done_count), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
